// File: rtl/wb_irq_ctrl.sv
// Wishbone classic interrupt controller: latches, masks and prioritises up to
// NUM_IRQ level or rising-edge sources into a single registered CPU interrupt.
module wb_irq_ctrl #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               cyc_i,
   input  logic               stb_i,
   input  logic [2:0]         adr_i,
   input  logic               we_i,
   input  logic [3:0]         sel_i,
   input  logic [31:0]        dat_i,
   output logic [31:0]        dat_o,
   output logic               ack_o,
   input  logic [NUM_IRQ-1:0] irq_i,
   output logic               int_o
);

   // Internal state is kept 32 bits wide; bits at and above NUM_IRQ stay 0.
   localparam logic [31:0] VALID = 32'((64'h1 << NUM_IRQ) - 64'h1);

   logic [31:0] irq_ext;
   logic [31:0] irq_q;
   logic [31:0] edge_latch;
   logic [31:0] enable_q;
   logic [31:0] edge_q;
   logic [31:0] pending;
   logic [31:0] active;
   logic [31:0] rise;
   logic [31:0] byte_mask;
   logic [31:0] wbits;
   logic [31:0] w1c;
   logic [31:0] swset;
   logic [31:0] rd_data;
   logic [4:0]  id_idx;
   logic        req;
   logic        wr;

   assign irq_ext   = 32'(irq_i);
   assign req       = cyc_i & stb_i & ~ack_o;
   assign wr        = req & we_i;
   assign byte_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
   assign wbits     = dat_i & byte_mask & VALID;
   assign w1c       = (wr && adr_i == 3'd0) ? wbits : 32'h0;
   assign swset     = (wr && adr_i == 3'd5) ? wbits : 32'h0;
   assign rise      = irq_ext & ~irq_q;

   // Level sources pass straight through; edge sources come from the latch.
   assign pending = (edge_q & edge_latch) | (~edge_q & irq_ext);
   assign active  = pending & enable_q;

   always_comb begin
      id_idx = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (active[i]) begin
            id_idx = 5'(i);
         end
      end
   end

   always_comb begin
      rd_data = 32'h0;
      case (adr_i)
         3'd0:    rd_data = pending;
         3'd1:    rd_data = enable_q;
         3'd2:    rd_data = edge_q;
         3'd3:    rd_data = active;
         3'd4:    rd_data = {(|active), 26'h0, id_idx};
         default: rd_data = 32'h0;
      endcase
   end

   // The latch is masked by the current edge config so that a bit switched
   // from level to edge always starts out cleared; a rise beats a W1C.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         irq_q      <= 32'h0;
         edge_latch <= 32'h0;
         enable_q   <= 32'h0;
         edge_q     <= 32'h0;
         ack_o      <= 1'b0;
         dat_o      <= 32'h0;
         int_o      <= 1'b0;
      end else begin
         irq_q      <= irq_ext;
         edge_latch <= ((edge_latch & ~w1c) | rise | swset) & edge_q;
         if (wr && adr_i == 3'd1) begin
            enable_q <= (enable_q & ~(byte_mask & VALID)) | wbits;
         end
         if (wr && adr_i == 3'd2) begin
            edge_q <= (edge_q & ~(byte_mask & VALID)) | wbits;
         end
         ack_o <= req;
         if (req) begin
            dat_o <= rd_data;
         end
         int_o <= |active;
      end
   end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Self-checking bench for wb_irq_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_wb_irq_ctrl;

   localparam int NUM_IRQ = 8;

   logic               clk_i;
   logic               rst_n_i;
   logic               cyc_i;
   logic               stb_i;
   logic [2:0]         adr_i;
   logic               we_i;
   logic [3:0]         sel_i;
   logic [31:0]        dat_i;
   logic [31:0]        dat_o;
   logic               ack_o;
   logic [NUM_IRQ-1:0] irq_i;
   logic               int_o;

   int vectors;
   int miscompares;

   logic [31:0] m_en;
   logic [31:0] m_ed;
   logic [31:0] m_lat;
   logic [31:0] m_prev;
   logic        m_ack;
   logic        m_int;
   logic [31:0] m_dat;

   wb_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .cyc_i   (cyc_i),
      .stb_i   (stb_i),
      .adr_i   (adr_i),
      .we_i    (we_i),
      .sel_i   (sel_i),
      .dat_i   (dat_i),
      .dat_o   (dat_o),
      .ack_o   (ack_o),
      .irq_i   (irq_i),
      .int_o   (int_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference view of the register file, built bit by bit from the source rules.
   function automatic logic [31:0] modelRead(input logic [2:0] a);
      logic [31:0] pend;
      logic [31:0] act;
      logic [31:0] r;
      pend = 32'h0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         pend[i] = m_ed[i] ? m_lat[i] : irq_i[i];
      end
      act = pend & m_en;
      r = 32'h0;
      case (a)
         3'd0: r = pend;
         3'd1: r = m_en;
         3'd2: r = m_ed;
         3'd3: r = act;
         3'd4: begin
            for (int i = 0; i < 32; i++) begin
               if (act[i] && !r[31]) begin
                  r = 32'h8000_0000 + i;
               end
            end
         end
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   always @(posedge clk_i or negedge rst_n_i) begin
      logic        req;
      logic        wr;
      logic        lane;
      logic        wbit;
      logic        rise;
      logic [31:0] rv;
      if (!rst_n_i) begin
         m_en   = 32'h0;
         m_ed   = 32'h0;
         m_lat  = 32'h0;
         m_prev = 32'h0;
         m_ack  = 1'b0;
         m_int  = 1'b0;
         m_dat  = 32'h0;
      end else begin
         req = cyc_i && stb_i && !m_ack;
         wr  = req && we_i;
         rv  = modelRead(adr_i);
         m_int = (modelRead(3'd3) != 32'h0);
         for (int i = 0; i < NUM_IRQ; i++) begin
            lane = sel_i[i / 8];
            wbit = dat_i[i] && lane;
            rise = irq_i[i] && !m_prev[i];
            if (!m_ed[i]) begin
               m_lat[i] = 1'b0;
            end else if (rise || (wr && adr_i == 3'd5 && wbit)) begin
               m_lat[i] = 1'b1;
            end else if (wr && adr_i == 3'd0 && wbit) begin
               m_lat[i] = 1'b0;
            end
            if (wr && adr_i == 3'd1 && lane) m_en[i] = dat_i[i];
            if (wr && adr_i == 3'd2 && lane) m_ed[i] = dat_i[i];
            m_prev[i] = irq_i[i];
         end
         m_ack = req;
         if (req) m_dat = rv;
      end
   end

   always @(negedge clk_i) begin
      checkOutput("ack_o", {31'h0, ack_o}, {31'h0, m_ack});
      checkOutput("int_o", {31'h0, int_o}, {31'h0, m_int});
      checkOutput("dat_o", dat_o, m_dat);
   end

   // One Wishbone transfer, started and finished just after a rising edge.
   task automatic applyStimulus(input logic we, input logic [2:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd);
      logic got;
      got   = 1'b0;
      rd    = 32'h0;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = we;
      adr_i = a;
      dat_i = d;
      sel_i = s;
      for (int k = 0; k < 4 && !got; k++) begin
         @(posedge clk_i);
         #1;
         if (ack_o) begin
            got = 1'b1;
            rd  = dat_o;
         end
      end
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i  = 1'b0;
      if (!got) checkOutput("ack_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [31:0] rd;
      vectors     = 0;
      miscompares = 0;
      rst_n_i = 1'b0;
      cyc_i   = 1'b0;
      stb_i   = 1'b0;
      we_i    = 1'b0;
      adr_i   = 3'd0;
      sel_i   = 4'h0;
      dat_i   = 32'h0;
      irq_i   = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_n_i = 1'b1;

      // Reset asserted in the middle of a transfer.
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 3'd1; dat_i = 32'hFF; sel_i = 4'hF;
      @(posedge clk_i);
      #1 rst_n_i = 1'b0;
      #2;
      checkOutput("reset_ack", {31'h0, ack_o}, 32'h0);
      checkOutput("reset_int", {31'h0, int_o}, 32'h0);
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      @(posedge clk_i);
      #1 rst_n_i = 1'b1;
      for (int a = 0; a < 5; a++) begin
         applyStimulus(1'b0, 3'(a), 32'h0, 4'hF, rd);
         checkOutput($sformatf("reset_read%0d", a), rd, 32'h0);
      end

      // Edge path on source 0.
      applyStimulus(1'b1, 3'd1, 32'h01, 4'hF, rd);
      applyStimulus(1'b1, 3'd2, 32'h01, 4'hF, rd);
      irq_i = 8'h01;
      @(posedge clk_i); #1;
      checkOutput("edge_int_1clk", {31'h0, int_o}, 32'h0);
      irq_i = 8'h00;
      @(posedge clk_i); #1;
      checkOutput("edge_int_2clk", {31'h0, int_o}, 32'h1);
      applyStimulus(1'b0, 3'd0, 32'h0, 4'hF, rd);
      checkOutput("edge_pend", rd, 32'h01);
      applyStimulus(1'b0, 3'd4, 32'h0, 4'hF, rd);
      checkOutput("edge_id", rd, 32'h8000_0000);
      applyStimulus(1'b1, 3'd0, 32'h01, 4'hF, rd);
      @(posedge clk_i); #1;
      checkOutput("edge_w1c_int", {31'h0, int_o}, 32'h0);

      // Level path on sources 2 and 3.
      applyStimulus(1'b1, 3'd1, 32'h0C, 4'hF, rd);
      applyStimulus(1'b1, 3'd2, 32'h00, 4'hF, rd);
      irq_i = 8'h0C;
      applyStimulus(1'b0, 3'd4, 32'h0, 4'hF, rd);
      checkOutput("level_id", rd, 32'h8000_0002);
      applyStimulus(1'b1, 3'd0, 32'h0C, 4'hF, rd);
      applyStimulus(1'b0, 3'd0, 32'h0, 4'hF, rd);
      checkOutput("level_pend_after_w1c", rd, 32'h0C);
      checkOutput("level_int_high", {31'h0, int_o}, 32'h1);
      irq_i = 8'h00;
      @(posedge clk_i); #1;
      checkOutput("level_int_low", {31'h0, int_o}, 32'h0);

      // Rise on bit 3 in the same cycle as its W1C.
      applyStimulus(1'b1, 3'd2, 32'h08, 4'hF, rd);
      applyStimulus(1'b1, 3'd1, 32'h08, 4'hF, rd);
      irq_i = 8'h08;
      @(posedge clk_i); #1;
      irq_i = 8'h00;
      @(posedge clk_i); #1;
      irq_i = 8'h08;
      applyStimulus(1'b1, 3'd0, 32'h08, 4'hF, rd);
      applyStimulus(1'b0, 3'd0, 32'h0, 4'hF, rd);
      checkOutput("set_beats_clear", rd, 32'h08);
      irq_i = 8'h00;

      // Byte lanes and software set.
      applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFF, 4'h1, rd);
      applyStimulus(1'b0, 3'd1, 32'h0, 4'hF, rd);
      checkOutput("enable_lane0", rd, 32'hFF);
      applyStimulus(1'b1, 3'd2, 32'hF0, 4'hF, rd);
      applyStimulus(1'b1, 3'd5, 32'hFF, 4'hF, rd);
      applyStimulus(1'b0, 3'd0, 32'h0, 4'hF, rd);
      checkOutput("swset_pend", rd, 32'hF0);
      applyStimulus(1'b0, 3'd4, 32'h0, 4'hF, rd);
      checkOutput("swset_id", rd, 32'h8000_0004);

      // Held strobe on unmapped offset 7.
      @(posedge clk_i); #1;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd7;
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("held_ack%0d", k), {31'h0, ack_o}, 32'(k % 2));
         if (k % 2 == 1) checkOutput($sformatf("held_dat%0d", k), dat_o, 32'h0);
         @(posedge clk_i); #1;
      end
      cyc_i = 1'b0; stb_i = 1'b0;

      // Randomized traffic against the model, with one asynchronous reset pulse.
      for (int n = 0; n < 3000; n++) begin
         irq_i = NUM_IRQ'($urandom);
         cyc_i = ($urandom_range(0, 3) != 0);
         stb_i = ($urandom_range(0, 3) != 0);
         we_i  = ($urandom_range(0, 1) != 0);
         adr_i = 3'($urandom_range(0, 7));
         sel_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         dat_i = $urandom;
         if (n == 1500) begin
            #2 rst_n_i = 1'b0;
            #2 rst_n_i = 1'b1;
         end
         @(posedge clk_i); #1;
      end
      cyc_i = 1'b0; stb_i = 1'b0;
      @(posedge clk_i); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
- Wishbone classic slave interrupt controller, directly downstream of the timer and other peripheral interrupt lines.
- Collects up to NUM_IRQ interrupt sources, each configurable as level or rising-edge.
- Latches, masks and prioritises the sources and drives a single registered interrupt to the CPU.
- Sits beside the timer behind its own axi4lite_to_wishbone bridge; uses the same 32-bit Wishbone signal set and adr_i[4:2] word addressing.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..32); register bits at and above NUM_IRQ read 0 and ignore writes.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- adr_i  in  3  word address (byte address bits 4:2).
- we_i  in  1  write enable.
- sel_i  in  4  byte lane select for writes.
- dat_i  in  32  write data.
- dat_o  out  32  read data, registered.
- ack_o  out  1  transfer acknowledge, registered.
- irq_i  in  NUM_IRQ  interrupt sources, synchronous to clk_i, bit 0 = timer int_o.
- int_o  out  1  combined interrupt to CPU, registered.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. On reset assertion, all of the following clear to 0 immediately, independent of clk_i: pending, enable, edge, irq_q, ack_o, dat_o, int_o.
- Register map (word offset):
  - 0 PEND: R; W1C, clears edge-type pending bits only.
  - 1 ENABLE: RW.
  - 2 EDGE: RW; 1 = rising edge, 0 = level.
  - 3 ACTIVE: RO; pending & enable.
  - 4 ID: RO; bit31 = any active; bits 4:0 = lowest-numbered active index, 0 when none.
  - 5 SWSET: WO; 1 sets pending on edge-type bits, level-type bits unaffected.
  - 6-7: read 0, writes ignored.
  - Writes to RO offsets are ignored.
- Level source: pending[i] = irq_i[i] combinationally each cycle; there is no latch, so W1C has no effect.
- Edge source:
  - irq_q is irq_i registered every cycle.
  - A rise is irq_i & ~irq_q; a rise sets pending[i].
  - Pending stays set until W1C.
  - If a rise and a W1C of the same bit occur in the same cycle, set wins.
  - A source already high at reset release registers as a rise in the first clock edge after reset release.
  - Switching a bit from level to edge leaves its latch cleared (0).
- Byte lanes: a write updates register bits [8k+7:8k] only when sel_i[k]=1.
- Wishbone handshake:
  - Transfer request is cyc_i & stb_i & ~ack_o, sampled at a rising edge.
  - The next cycle, ack_o=1 for exactly one cycle, and dat_o holds the read value sampled at the request edge.
  - Write effects become visible in the same cycle that ack_o rises.
  - While ack_o=1 no new request is accepted, so a held strobe gets ack every other cycle.
  - If stb_i drops before ack, ack_o still pulses; the master ignores it.
  - dat_o holds its last value when not acking.
- int_o: registered |(pending & enable). Latency is 1 clk from a pending/enable change, so 2 clks from an edge-source rise.
- Priority: lowest index wins. ID is combinational from current state and is captured into dat_o with the normal read latency.

Test Plan:
- Reset: hold rst_n_i low mid-transfer, release -> ack_o=0, int_o=0, reads of offsets 0-4 return 0x0, 0x0, 0x0, 0x0, 0x0.
- Edge path:
  - Stimulus: write ENABLE=0x01, EDGE=0x01, then pulse irq_i[0] for 1 clk.
  - Required: int_o=1 two clks after the rise; PEND reads 0x01; ID reads 0x80000000.
  - Then write PEND=0x01 -> int_o=0 one clk after ack.
- Level path:
  - Stimulus: write ENABLE=0x0C, EDGE=0x00, irq_i=0x0C.
  - Required: ID reads 0x80000002; W1C PEND=0x0C leaves PEND=0x0C.
  - Then irq_i=0 -> int_o=0 one clk later.
- Simultaneous set/clear: edge bit 3 pending, W1C of bit 3 in the same cycle as a new rise on irq_i[3] -> PEND still reads 0x08.
- Byte lanes and SWSET:
  - Write ENABLE=0xFFFFFFFF with sel_i=0x1 (NUM_IRQ=8) -> ENABLE reads 0xFF.
  - Write EDGE=0xF0, then SWSET=0xFF -> PEND reads 0xF0.
- Handshake: hold cyc_i=stb_i=1 for 6 clks on a read -> ack_o pattern 0,1,0,1,0,1; an unmapped offset 7 read returns 0.
